// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max pooling over the two Layer 0 maps, writing each result to
// its Layer 1 map and to the interleaved Layer 2 flatten memory.
module maxpool_flatten #(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int CW = $clog2(IMG_W / 2);
  localparam int PW = 2 * CW;
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_LAST = '1;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
  localparam logic [2:0] SEL_L2F  = 3'b101;

  typedef enum logic [2:0] {IDLE, RD, LAST, WR1, WR2, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] p, p_n;
  logic          k, k_n;
  logic [1:0]    j, j_n;
  logic [DW-1:0] max_q, max_n;

  logic          busy_n, done_n, crd_n, cwr_n;
  logic [AW-1:0] caddr_rd_n, caddr_wr_n;
  logic [DW-1:0] cdata_wr_n;
  logic [2:0]    csel_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      p        <= '0;
      k        <= 1'b0;
      j        <= 2'd0;
      max_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= SEL_NONE;
    end else begin
      state    <= state_n;
      p        <= p_n;
      k        <= k_n;
      j        <= j_n;
      max_q    <= max_n;
      busy     <= busy_n;
      done     <= done_n;
      crd      <= crd_n;
      cwr      <= cwr_n;
      caddr_rd <= caddr_rd_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
      csel     <= csel_n;
    end
  end

  // Read data lags crd by one cycle, so RD j=1 sees element 0 and LAST sees element 3.
  always_comb begin
    state_n = state;
    p_n     = p;
    k_n     = k;
    j_n     = j;
    max_n   = max_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RD;
          p_n     = '0;
          k_n     = 1'b0;
          j_n     = 2'd0;
        end
      end
      RD: begin
        j_n = j + 2'd1;
        if (j == 2'd1) begin
          max_n = cdata_rd;
        end else if (j != 2'd0 && cdata_rd > max_q) begin
          max_n = cdata_rd;
        end
        if (j == 2'd3) begin
          state_n = LAST;
        end
      end
      LAST: begin
        if (cdata_rd > max_q) begin
          max_n = cdata_rd;
        end
        state_n = WR1;
      end
      WR1: state_n = WR2;
      WR2: begin
        if (!k) begin
          k_n     = 1'b1;
          state_n = RD;
        end else begin
          k_n = 1'b0;
          p_n = p + P_ONE;
          state_n = (p == P_LAST) ? DONE : RD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    busy_n     = 1'b0;
    done_n     = 1'b0;
    crd_n      = 1'b0;
    cwr_n      = 1'b0;
    caddr_rd_n = '0;
    caddr_wr_n = '0;
    cdata_wr_n = '0;
    csel_n     = SEL_NONE;
    case (state_n)
      RD: begin
        busy_n     = 1'b1;
        crd_n      = 1'b1;
        csel_n     = k_n ? SEL_L0K1 : SEL_L0K0;
        caddr_rd_n = AW'({p_n[PW-1:CW], j_n[1], p_n[CW-1:0], j_n[0]});
      end
      LAST: begin
        busy_n = 1'b1;
        csel_n = k_n ? SEL_L0K1 : SEL_L0K0;
      end
      WR1: begin
        busy_n     = 1'b1;
        cwr_n      = 1'b1;
        csel_n     = k_n ? SEL_L1K1 : SEL_L1K0;
        caddr_wr_n = AW'(p_n);
        cdata_wr_n = max_n;
      end
      WR2: begin
        busy_n     = 1'b1;
        cwr_n      = 1'b1;
        csel_n     = SEL_L2F;
        caddr_wr_n = AW'({p_n, k_n});
        cdata_wr_n = max_n;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Self-checking bench for maxpool_flatten: memory model plus a write scoreboard
// filled from a reference pooling model whenever a run is launched.
module tb_maxpool_flatten;

  localparam int BUSY_LEN = 14336;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;
  logic [2:0]  csel;

  typedef struct packed {
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [19:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  logic [19:0] l0k0[4096];
  logic [19:0] l0k1[4096];
  logic [19:0] l1k0[1024];
  logic [19:0] l1k1[1024];
  logic [19:0] l2f[2048];
  logic [19:0] rdata = '0;

  logic        tr_crd[8];
  logic        tr_cwr[8];
  logic [2:0]  tr_csel[8];
  logic [11:0] tr_rd[8];
  logic [11:0] tr_wr[8];

  assign cdata_rd = rdata;

  maxpool_flatten dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  // Result memory: one-cycle read latency, writes routed by csel.
  always @(posedge clk) begin
    if (crd) begin
      case (csel)
        3'd1:    rdata <= l0k0[caddr_rd];
        3'd2:    rdata <= l0k1[caddr_rd];
        default: rdata <= 'x;
      endcase
    end
    if (cwr) begin
      case (csel)
        3'd3:    l1k0[caddr_wr[9:0]] <= cdata_wr;
        3'd4:    l1k1[caddr_wr[9:0]] <= cdata_wr;
        3'd5:    l2f[caddr_wr[10:0]] <= cdata_wr;
        default: ;
      endcase
    end
  end

  // Write monitor pops the scoreboard on every DUT write.
  always @(negedge clk) begin
    if (reset === 1'b1 && (crd || cwr)) begin
      checks++;
      if (crd && cwr) begin
        errors++;
        $display("[TB] FAIL excl: crd=%b cwr=%b, required not both high", crd, cwr);
      end
      if (cwr) begin
        wr_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_underflow: write sel=%0d addr=%0d data=%h, required none", csel, caddr_wr, cdata_wr);
        end else begin
          e = sb.pop_front();
          if ({csel, caddr_wr, cdata_wr} !== e) begin
            errors++;
            $display("[TB] FAIL sb_write: got sel=%0d addr=%0d data=%h, required sel=%0d addr=%0d data=%h",
                     csel, caddr_wr, cdata_wr, e.sel, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic clear_results();
    for (int i = 0; i < 1024; i++) begin l1k0[i] = '0; l1k1[i] = '0; end
    for (int i = 0; i < 2048; i++) l2f[i] = '0;
  endtask

  task automatic launch(input bit hold);
    logic [19:0] m, v;
    wr_t e;
    for (int py = 0; py < 32; py++) begin
      for (int px = 0; px < 32; px++) begin
        for (int k = 0; k < 2; k++) begin
          m = '0;
          for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
              v = (k == 0) ? l0k0[(2*py+dy)*64 + 2*px+dx] : l0k1[(2*py+dy)*64 + 2*px+dx];
              if (v > m) m = v;
            end
          end
          e.sel = (k == 0) ? 3'd3 : 3'd4; e.addr = 12'(py*32+px); e.data = m;
          sb.push_back(e);
          e.sel = 3'd5; e.addr = 12'(2*(py*32+px)+k); e.data = m;
          sb.push_back(e);
        end
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output int done_cnt, output int done_at, output bit timeout);
    int tail = -1;
    busy_cnt = 0; done_cnt = 0; done_at = 0; timeout = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (c < 8) begin
        tr_crd[c] = crd; tr_cwr[c] = cwr; tr_csel[c] = csel;
        tr_rd[c] = caddr_rd; tr_wr[c] = caddr_wr;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        start = 1'b0;
        if (tail < 0) begin tail = 20; done_at = c; timeout = 1'b0; end
      end
      if (tail > 0) tail--;
      if (tail == 0) break;
    end
  endtask

  task automatic check_run(input string tag);
    int bc, dc, da;
    bit to;
    wait_done(bc, dc, da, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL %s_timeout: no done within 20000 cycles", tag); end
    checks++;
    if (bc !== BUSY_LEN) begin errors++; $display("[TB] FAIL %s_busy_len: got %0d, required %0d", tag, bc, BUSY_LEN); end
    checks++;
    if (dc !== 1) begin errors++; $display("[TB] FAIL %s_done_count: got %0d, required 1", tag, dc); end
    checks++;
    if (da !== BUSY_LEN + 1) begin errors++; $display("[TB] FAIL %s_done_cycle: got %0d, required %0d", tag, da, BUSY_LEN + 1); end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("[TB] FAIL %s_sb_left: got %0d pending, required 0", tag, sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_during: busy=%b done=%b crd=%b cwr=%b csel=%0d ard=%0d awr=%0d dwr=%h, required all 0",
               busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_after: busy=%b done=%b crd=%b cwr=%b csel=%0d, required all 0", busy, done, crd, cwr, csel);
    end
  endtask

  task automatic test_ramp_timing();
    int ea[4] = '{0, 1, 64, 65};
    for (int a = 0; a < 4096; a++) begin l0k0[a] = 20'(a); l0k1[a] = 20'(4095 - a); end
    clear_results();
    launch(1'b0);
    check_run("ramp");
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (tr_crd[i] !== 1'b1 || tr_csel[i] !== 3'd1 || tr_rd[i] !== 12'(ea[i-1])) begin
        errors++;
        $display("[TB] FAIL first_read%0d: crd=%b csel=%0d addr=%0d, required crd=1 csel=1 addr=%0d",
                 i, tr_crd[i], tr_csel[i], tr_rd[i], ea[i-1]);
      end
    end
    checks++;
    if (tr_crd[5] !== 1'b0 || tr_cwr[5] !== 1'b0 || tr_csel[5] !== 3'd1) begin
      errors++;
      $display("[TB] FAIL last_cycle: crd=%b cwr=%b csel=%0d, required 0 0 1", tr_crd[5], tr_cwr[5], tr_csel[5]);
    end
    checks++;
    if (tr_cwr[6] !== 1'b1 || tr_csel[6] !== 3'd3 || tr_wr[6] !== 12'd0) begin
      errors++;
      $display("[TB] FAIL first_wr1: cwr=%b csel=%0d addr=%0d, required 1 3 0", tr_cwr[6], tr_csel[6], tr_wr[6]);
    end
    checks++;
    if (tr_cwr[7] !== 1'b1 || tr_csel[7] !== 3'd5 || tr_wr[7] !== 12'd0) begin
      errors++;
      $display("[TB] FAIL first_wr2: cwr=%b csel=%0d addr=%0d, required 1 5 0", tr_cwr[7], tr_csel[7], tr_wr[7]);
    end
    checks++;
    if ({l1k0[0], l1k0[1023], l1k1[0], l1k1[1023]} !== {20'd65, 20'd4095, 20'd4095, 20'd65}) begin
      errors++;
      $display("[TB] FAIL ramp_l1: got %0d %0d %0d %0d, required 65 4095 4095 65", l1k0[0], l1k0[1023], l1k1[0], l1k1[1023]);
    end
    checks++;
    if ({l2f[0], l2f[1], l2f[2046], l2f[2047]} !== {20'd65, 20'd4095, 20'd4095, 20'd65}) begin
      errors++;
      $display("[TB] FAIL ramp_l2f: got %0d %0d %0d %0d, required 65 4095 4095 65", l2f[0], l2f[1], l2f[2046], l2f[2047]);
    end
  endtask

  task automatic test_unsigned_max();
    for (int a = 0; a < 4096; a++) begin
      l0k0[a] = 20'($urandom); l0k1[a] = 20'($urandom);
    end
    l0k0[0] = 20'h80000; l0k0[1] = 20'h7FFFF; l0k0[64] = 20'h0; l0k0[65] = 20'h00001;
    l0k0[2] = 20'hFFFFF; l0k0[3] = 20'hFFFFF; l0k0[66] = 20'hFFFFF; l0k0[67] = 20'hFFFFF;
    clear_results();
    launch(1'b0);
    check_run("umax");
    checks++;
    if (l1k0[0] !== 20'h80000 || l2f[0] !== 20'h80000) begin
      errors++;
      $display("[TB] FAIL umax_msb: got l1=%h l2f=%h, required 80000", l1k0[0], l2f[0]);
    end
    checks++;
    if (l1k0[1] !== 20'hFFFFF || l2f[2] !== 20'hFFFFF) begin
      errors++;
      $display("[TB] FAIL umax_ones: got l1=%h l2f=%h, required fffff", l1k0[1], l2f[2]);
    end
  endtask

  task automatic test_reset_mid();
    clear_results();
    launch(1'b0);
    repeat (4999) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: busy=%b crd=%b cwr=%b csel=%0d ard=%0d awr=%0d, required all 0",
               busy, crd, cwr, csel, caddr_rd, caddr_wr);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    launch(1'b0);
    check_run("restart");
  endtask

  task automatic test_start_held();
    clear_results();
    launch(1'b1);
    check_run("held");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_timing();
    test_unsigned_max();
    test_reset_mid();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
